fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core; sits directly upstream of the decode-stage control unit. Owns the PC and drives a request/ready instruction-memory port. Buffers one returned instruction while decode stalls. Presents Opcode/func/Rs/Rt/Rd/imm16 to decode, and applies the PCSrc redirect that the control unit returns, with no branch delay slot.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded by reset.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
PCSrc  in  2  from control unit: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
br_target  in  32  branch target computed in ID
jr_target  in  32  Rs value for jr/jalr
stall  in  1  hazard unit: hold IF/ID contents
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_rdata  in  32  instruction; valid when imem_ready=1
imem_ready  in  1  completes outstanding request, 1+ cycles after req
instr_id  out  32  IF/ID instruction; 0 (sll nop) when bubble
pc_plus4_id  out  32  address of instr_id + 4
valid_id  out  1  IF/ID holds a real instruction
Opcode  out  6  instr_id[31:26]
func  out  6  instr_id[5:0]
Rs  out  5  instr_id[25:21]
Rt  out  5  instr_id[20:16]
Rd  out  5  instr_id[15:11]
imm16  out  16  instr_id[15:0]

Behaviour:
- Reset (rst=1 at edge): req_addr=RESET_PC, state=S_REQ, instr_id=0, pc_plus4_id=0, valid_id=0, buffer cleared. imem_req is 0 while rst is high.
- redirect = valid_id & !stall & (PCSrc!=0). Target selection:
  - 01: br_target.
  - 10: {pc_plus4_id[31:28], instr_id[25:0], 2'b00}.
  - 11: jr_target.
- IF/ID update:
  - stall=1: all IF/ID registers hold, including a bubble.
  - stall=0: load the instruction delivered this cycle, or else a bubble (instr_id=0, valid_id=0).
  - Redirect always makes the next IF/ID a bubble.
- Handshake:
  - imem_addr and imem_req stay stable from assertion until the cycle imem_ready=1.
  - At most one request is outstanding.
  - imem_ready while imem_req=0 is ignored.
- FSM:
  - S_REQ: imem_req=1, imem_addr=req_addr.
    - ready & redirect: drop rdata; req_addr<=target; stay S_REQ (new address next cycle).
    - ready & !stall: IF/ID<=rdata, pc_plus4_id<=req_addr+4, valid_id<=1, req_addr<=req_addr+4.
    - ready & stall: buf<=rdata; go S_HOLD.
    - !ready & redirect: pending<=target; go S_DISCARD.
    - !ready & !redirect: wait.
  - S_HOLD: imem_req=0.
    - redirect: drop buf; req_addr<=target; go S_REQ.
    - !stall: IF/ID<=buf, pc_plus4_id<=req_addr+4, valid_id<=1, req_addr<=req_addr+4; go S_REQ.
  - S_DISCARD: imem_req=1 at the old address.
    - On ready: drop rdata; req_addr<=pending; go S_REQ.
    - No redirect can occur here, because IF/ID is a bubble.
- Throughput: with imem_ready same-cycle-as-request every cycle and no stalls, one instruction per cycle.
- Redirect penalty:
  - From S_REQ with ready: 1 bubble.
  - From S_DISCARD: 1 + remaining memory latency.
- Arithmetic: req_addr+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Targets with nonzero bits [1:0] are forced to 0 on imem_addr.
- Reset mid-operation: an in-flight response arriving after reset is ignored unless imem_req=1 at that edge. Memory must drop an outstanding request on rst.

Test Plan:
- Reset then ready held 1, no stall -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; valid_id=1 from the 2nd cycle; pc_plus4_id=0x3004 for the first instruction.
- Fetch 0x3004 returns while stall=1 for 3 cycles -> imem_req=0 and IF/ID unchanged for 3 cycles; the buffered instruction enters ID on the first cycle stall=0; next imem_addr=0x3008.
- IF/ID holds beq with PCSrc=01, br_target=0x3040, while the request to 0x3008 has ready=0 for 2 cycles -> S_DISCARD; 0x3008 data is never loaded; valid_id=0; next request is 0x3040.
- instr_id=j 0x0000100 with pc_plus4_id=0x0000_3010, PCSrc=10 -> next imem_addr=0x0000_0400; one bubble in ID.
- jr with jr_target=0x0000_5008 in the same cycle that stall=1 -> no redirect; the redirect is taken in the cycle stall drops and the next request is 0x5008.
- Sequential fetch at req_addr=0xFFFF_FFFC -> next imem_addr=0x0000_0000. Separately, rst asserted during S_DISCARD -> next cycle state S_REQ, imem_addr=0x3000, valid_id=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/ready port used by the fetch stage.
//   imem_req   : fetch request valid (fetch -> memory)
//   imem_addr  : word-aligned fetch address (fetch -> memory)
//   imem_rdata : returned instruction, valid when imem_ready=1 (memory -> fetch)
//   imem_ready : completes the outstanding request (memory -> fetch)
// Modports: master = fetch stage side, slave = instruction memory side.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage plus IF/ID pipeline register of the pipelined MIPS
// core. Owns the PC, issues one instruction-memory request at a time, buffers
// one returned instruction while decode stalls, and applies the PCSrc redirect
// returned by the decode-stage control unit (no branch delay slot).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   PCSrc        : 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   br_target    : branch target computed in ID
//   jr_target    : Rs value for jr/jalr
//   stall        : hazard unit hold of IF/ID
//   imem         : instruction-memory port (master side)
//   instr_id     : IF/ID instruction, 0 (sll nop) on a bubble
//   pc_plus4_id  : address of instr_id + 4
//   valid_id     : IF/ID holds a real instruction
//   Opcode, func, Rs, Rt, Rd, imm16 : decode fields sliced from instr_id
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           PCSrc,
  input  logic [31:0]          br_target,
  input  logic [31:0]          jr_target,
  input  logic                 stall,
  fetch_stage_if.master        imem,
  output logic [31:0]          instr_id,
  output logic [31:0]          pc_plus4_id,
  output logic                 valid_id,
  output logic [5:0]           Opcode,
  output logic [5:0]           func,
  output logic [4:0]           Rs,
  output logic [4:0]           Rt,
  output logic [4:0]           Rd,
  output logic [15:0]          imm16
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_req_addr;
  logic [31:0] w_req_addr_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic [31:0] r_instr_id;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pc_plus4_id;
  logic [31:0] w_pc_plus4_nxt;
  logic        r_valid_id;
  logic        w_valid_nxt;

  logic        w_redirect;
  logic        w_ready;
  logic [31:0] w_seq_addr;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_target;

  // A redirect is only honoured for a real instruction that is leaving ID.
  assign w_redirect = r_valid_id & ~stall & (PCSrc != 2'b00);
  // A ready pulse without an active request is ignored.
  assign w_ready    = imem.imem_ready & imem.imem_req;
  // Wraps modulo 2^32 naturally.
  assign w_seq_addr = r_req_addr + 32'd4;
  // Low address bits of any target are cleared so fetches stay word aligned.
  assign w_target   = w_tgt_raw & 32'hFFFF_FFFC;

  // Memory request is suppressed during reset and while an instruction is buffered.
  assign imem.imem_req  = ~rst & (r_state != S_HOLD);
  assign imem.imem_addr = r_req_addr & 32'hFFFF_FFFC;

  assign instr_id    = r_instr_id;
  assign pc_plus4_id = r_pc_plus4_id;
  assign valid_id    = r_valid_id;
  assign Opcode      = r_instr_id[31:26];
  assign func        = r_instr_id[5:0];
  assign Rs          = r_instr_id[25:21];
  assign Rt          = r_instr_id[20:16];
  assign Rd          = r_instr_id[15:11];
  assign imm16       = r_instr_id[15:0];

  // Redirect target selection from the control unit's PCSrc.
  always_comb begin
    w_tgt_raw = w_seq_addr;
    case (PCSrc)
      2'b01:   w_tgt_raw = br_target;
      2'b10:   w_tgt_raw = {r_pc_plus4_id[31:28], r_instr_id[25:0], 2'b00};
      2'b11:   w_tgt_raw = jr_target;
      default: w_tgt_raw = w_seq_addr;
    endcase
  end

  // Fetch FSM next-state and IF/ID next-value logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_addr_nxt = r_req_addr;
    w_buf_nxt      = r_buf;
    w_pending_nxt  = r_pending;
    w_pc_plus4_nxt = r_pc_plus4_id;
    // Without a stall IF/ID becomes a bubble unless a load below overrides it.
    if (stall) begin
      w_instr_nxt = r_instr_id;
      w_valid_nxt = r_valid_id;
    end else begin
      w_instr_nxt = 32'h0000_0000;
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      S_REQ: begin
        if (w_ready && w_redirect) begin
          // Returned word is on the wrong path: drop it and refetch at target.
          w_req_addr_nxt = w_target;
        end else if (w_ready && !stall) begin
          w_instr_nxt    = imem.imem_rdata;
          w_pc_plus4_nxt = w_seq_addr;
          w_valid_nxt    = 1'b1;
          w_req_addr_nxt = w_seq_addr;
        end else if (w_ready) begin
          w_buf_nxt   = imem.imem_rdata;
          w_state_nxt = S_HOLD;
        end else if (w_redirect) begin
          // The request cannot be withdrawn; remember the target until it completes.
          w_pending_nxt = w_target;
          w_state_nxt   = S_DISCARD;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_req_addr_nxt = w_target;
          w_state_nxt    = S_REQ;
        end else if (!stall) begin
          w_instr_nxt    = r_buf;
          w_pc_plus4_nxt = w_seq_addr;
          w_valid_nxt    = 1'b1;
          w_req_addr_nxt = w_seq_addr;
          w_state_nxt    = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DISCARD: begin
        // IF/ID is a bubble here, so no further redirect can arrive.
        if (w_ready) begin
          w_req_addr_nxt = r_pending;
          w_state_nxt    = S_REQ;
        end else begin
          w_state_nxt = S_DISCARD;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // State, PC, buffer and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_req_addr    <= RESET_PC;
      r_buf         <= 32'h0000_0000;
      r_pending     <= 32'h0000_0000;
      r_instr_id    <= 32'h0000_0000;
      r_pc_plus4_id <= 32'h0000_0000;
      r_valid_id    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_addr    <= w_req_addr_nxt;
      r_buf         <= w_buf_nxt;
      r_pending     <= w_pending_nxt;
      r_instr_id    <= w_instr_nxt;
      r_pc_plus4_id <= w_pc_plus4_nxt;
      r_valid_id    <= w_valid_nxt;
    end
  end

endmodule
